// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB packet type and constants for the result-bus arbiter.
// Optional build macro: CDB_MEM_PRIORITY_EN (memory results win arbitration).
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU = 4;
  localparam int ROB_IDX_W  = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] dest_ROB_entry;
    logic [XLEN-1:0]      result;
    logic                 branch_result;
    logic                 from_memory;
  } CDB_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, mod N.
// Used once, or twice when CDB_MEM_PRIORITY_EN is defined.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  always_comb begin
    logic [IDX_W-1:0] j;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = '0;
    for (int k = 0; k < N; k++) begin
      j = IDX_W'((int'(ptr) + k) % N);
      if (!any_grant && req[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = j;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants one FU result per cycle onto the registered common data bus.
// Optional build macro: CDB_MEM_PRIORITY_EN (memory results win arbitration).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  localparam int IDX_W = $clog2(NUM_FU)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [NUM_FU-1:0] fu_valid,
  input  CDB_packet_t       fu_packet [NUM_FU],
  output logic [NUM_FU-1:0] fu_yumi,
  output logic              cdb_valid,
  output CDB_packet_t       cdb_out,
  output logic [IDX_W-1:0]  cdb_src
);

  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_FU-1:0] sel_grant;
  logic [IDX_W-1:0]  win;
  logic              any_req;
  logic              accept;

  logic [NUM_FU-1:0] all_grant;
  logic [IDX_W-1:0]  all_idx;
  logic              all_any;

  rr_arbiter #(.N(NUM_FU), .IDX_W(IDX_W)) u_all (
    .req      (fu_valid),
    .ptr      (rr_ptr),
    .grant    (all_grant),
    .grant_idx(all_idx),
    .any_grant(all_any)
  );

`ifdef CDB_MEM_PRIORITY_EN
  logic [NUM_FU-1:0] mem_req;
  logic [NUM_FU-1:0] mem_grant;
  logic [IDX_W-1:0]  mem_idx;
  logic              mem_any;

  always_comb begin
    mem_req = '0;
    for (int i = 0; i < NUM_FU; i++)
      mem_req[i] = fu_valid[i] & fu_packet[i].from_memory;
  end

  rr_arbiter #(.N(NUM_FU), .IDX_W(IDX_W)) u_mem (
    .req      (mem_req),
    .ptr      (rr_ptr),
    .grant    (mem_grant),
    .grant_idx(mem_idx),
    .any_grant(mem_any)
  );

  assign sel_grant = mem_any ? mem_grant : all_grant;
  assign win       = mem_any ? mem_idx   : all_idx;
`else
  assign sel_grant = all_grant;
  assign win       = all_idx;
`endif

  assign any_req = all_any;
  assign accept  = any_req && !flush && !reset;
  assign fu_yumi = accept ? sel_grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_out   <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      cdb_valid <= 1'b1;
      cdb_out   <= fu_packet[win];
      cdb_src   <= win;
      rr_ptr    <= (win == IDX_W'(NUM_FU - 1)) ? '0 : win + 1'b1;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table plus a randomised FU-protocol sequence for cdb_arbiter.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [N-1:0] fu_valid;
  CDB_packet_t fu_packet [N];
  logic [N-1:0] fu_yumi;
  logic        cdb_valid;
  CDB_packet_t cdb_out;
  logic [1:0]  cdb_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .fu_valid (fu_valid),
    .fu_packet(fu_packet),
    .fu_yumi  (fu_yumi),
    .cdb_valid(cdb_valid),
    .cdb_out  (cdb_out),
    .cdb_src  (cdb_src)
  );

  typedef struct {
    logic       rst;
    logic       fl;
    logic [3:0] v;
    logic [3:0] mem;
    logic [3:0] y;
    logic       cv;
    logic [1:0] src;
    logic       zero;
  } vec_t;

  vec_t tbl[$];

  function automatic CDB_packet_t pkt(input int i, input logic m);
    CDB_packet_t p;
    p.dest_ROB_entry = ROB_IDX_W'(3 + i);
    p.result         = XLEN'(5 + 16 * i);
    p.branch_result  = (i % 2) == 1;
    p.from_memory    = m;
    return p;
  endfunction

  function automatic vec_t mk(input logic rst, input logic fl,
                              input logic [3:0] v, input logic [3:0] mem,
                              input logic [3:0] y, input logic cv,
                              input logic [1:0] src, input logic zero);
    vec_t r;
    r.rst = rst; r.fl = fl; r.v = v; r.mem = mem;
    r.y = y; r.cv = cv; r.src = src; r.zero = zero;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t r;
    CDB_packet_t ep;
    logic [3:0] fv, gap, ey;
    int mptr, w;

    // rst fl valid mem yumi cv src zero
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b1110, 4'b0000, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'b1100, 4'b0000, 4'b0100, 1, 2, 0));
    tbl.push_back(mk(0, 0, 4'b1000, 4'b0000, 4'b1000, 1, 3, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 3, 0));
    tbl.push_back(mk(0, 0, 4'b0100, 4'b0000, 4'b0100, 1, 2, 0));
    tbl.push_back(mk(0, 0, 4'b1001, 4'b0000, 4'b1000, 1, 3, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'b0110, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0110, 4'b0000, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'b0100, 4'b0000, 4'b0100, 1, 2, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'b1001, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b1000, 4'b0000, 4'b1000, 1, 3, 0));
`ifdef CDB_MEM_PRIORITY_EN
    tbl.push_back(mk(0, 0, 4'b0101, 4'b0100, 4'b0100, 1, 2, 0));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0));
`else
    tbl.push_back(mk(0, 0, 4'b0101, 4'b0100, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'b0100, 4'b0100, 4'b0100, 1, 2, 0));
`endif
    tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl[$].src = tbl[$-1].src;
    tbl[$].mem = tbl[$-1].mem;

    reset = 1'b1;
    flush = 1'b0;
    fu_valid = '0;
    for (int i = 0; i < N; i++) fu_packet[i] = pkt(i, 1'b0);
    @(posedge clk);
    #1;

    foreach (tbl[n]) begin
      r = tbl[n];
      reset = r.rst;
      flush = r.fl;
      fu_valid = r.v;
      for (int i = 0; i < N; i++) fu_packet[i] = pkt(i, r.mem[i]);
      #3;
      chk($sformatf("yumi[%0d]", n), 64'(fu_yumi), 64'(r.y));
      @(posedge clk);
      #1;
      ep = r.zero ? '0 : pkt(int'(r.src), r.mem[r.src]);
      chk($sformatf("cdb_valid[%0d]", n), 64'(cdb_valid), 64'(r.cv));
      chk($sformatf("cdb_src[%0d]", n), 64'(cdb_src), 64'(r.src));
      chk($sformatf("cdb_out[%0d]", n), 64'(cdb_out), 64'(ep));
    end

    // FU protocol model: hold until yumi, drop, gap a cycle, maybe reassert.
    reset = 1'b1;
    flush = 1'b0;
    fu_valid = '0;
    for (int i = 0; i < N; i++) fu_packet[i] = pkt(i, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mptr = 0;
    fv = 4'b1111;
    gap = '0;
    for (int c = 0; c < 40; c++) begin
      fu_valid = fv;
      #3;
      ey = '0;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && fv[(mptr + k) % N]) w = (mptr + k) % N;
      if (w >= 0) ey[w] = 1'b1;
      chk($sformatf("rand_yumi[%0d]", c), 64'(fu_yumi), 64'(ey));
      @(posedge clk);
      #1;
      chk($sformatf("rand_cv[%0d]", c), 64'(cdb_valid), 64'(w >= 0));
      if (w >= 0) begin
        chk($sformatf("rand_src[%0d]", c), 64'(cdb_src), 64'(w));
        mptr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (gap[i]) gap[i] = 1'b0;
        else if (!fv[i]) fv[i] = ($urandom_range(0, 2) != 0);
      end
      if (w >= 0) begin
        fv[w] = 1'b0;
        gap[w] = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
